// File: rtl/pio_pulse_out_pkg.sv
// pio_pulse_out_pkg
//   Shared definitions for the pulse/level PIO output port:
//   address width, bus data width and the register word map.
package pio_pulse_out_pkg;

   localparam int ADDR_W = 3;
   localparam int BUS_W  = 32;

   // Register word addresses; any other address reads 0 and ignores writes.
   typedef enum logic [ADDR_W-1:0] {
      PIO_DATA  = 3'd0,
      PIO_SET   = 3'd1,
      PIO_CLEAR = 3'd2,
      PIO_MODE  = 3'd3,
      PIO_PLEN  = 3'd4,
      PIO_BUSY  = 3'd5
   } pio_reg_e;

endpackage

// File: rtl/pio_pulse_out_if.sv
// pio_pulse_out_if
//   Avalon-MM slave bundle for the PIO register file.
//   address    : register word address
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : read data, combinational (read latency 0)
//   master drives the request side, slave returns readdata.
interface pio_pulse_out_if;
   import pio_pulse_out_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [BUS_W-1:0]  writedata;
   logic [BUS_W-1:0]  readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/pio_pulse_out_chan.sv
// pio_pulse_out_chan
//   One output channel: either a software-held level or a self-clearing
//   one-shot pulse of programmable length.
//   clk, reset : clock, synchronous active-high reset
//   mode       : 1 = pulse channel, 0 = level channel
//   set        : set level / trigger pulse
//   clr        : clear level / abort pulse (wins over set and load)
//   load       : DATA register write this cycle
//   load_val   : level value (level mode) or trigger request (pulse mode)
//   len        : pulse length, 0 is treated as 1
//   mode_chg   : this channel's mode bit is being changed this cycle
//   out        : registered channel output
//   busy       : a pulse is running
module pio_pulse_out_chan #(
   parameter int   CNT_W   = 16,
   parameter logic RST_OUT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mode,
   input  logic             set,
   input  logic             clr,
   input  logic             load,
   input  logic             load_val,
   input  logic [CNT_W-1:0] len,
   input  logic             mode_chg,
   output logic             out,
   output logic             busy
);

   // Remaining high cycles of the running pulse, including the current one.
   logic [CNT_W-1:0] cnt;

   function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] l);
      return (l == '0) ? CNT_W'(1) : l;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         out <= RST_OUT;
         cnt <= '0;
      end else if (mode_chg || clr) begin
         out <= 1'b0;
         cnt <= '0;
      end else if (!mode) begin
         if (set)
            out <= 1'b1;
         else if (load)
            out <= load_val;
      end else if (set || (load && load_val)) begin
         // Trigger or retrigger: reloading keeps out high with no gap,
         // including when this lands on the last high cycle.
         cnt <= eff_len(len);
         out <= 1'b1;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
         out <= (cnt != CNT_W'(1));
      end
   end

   assign busy = (cnt != '0);

endmodule

// File: rtl/pio_pulse_out.sv
// pio_pulse_out
//   Avalon-MM output port with WIDTH channels. Each channel is a level
//   output or a self-clearing pulse of PLEN cycles, so a strobe needs one
//   write instead of set-then-clear.
//   clk, reset : clock, synchronous active-high reset
//   bus        : Avalon-MM slave (address, chipselect, write_n,
//                writedata, readdata with zero read latency)
//   out_port   : registered channel outputs
module pio_pulse_out
   import pio_pulse_out_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               CNT_W       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] RESET_MODE  = '0
) (
   input  logic             clk,
   input  logic             reset,
   pio_pulse_out_if.slave   bus,
   output logic [WIDTH-1:0] out_port
);

   logic             wr;
   logic             wr_data, wr_set, wr_clr, wr_mode, wr_plen;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] mode_q;
   logic [CNT_W-1:0] plen_q;
   logic [WIDTH-1:0] busy;
   logic [BUS_W-1:0] rd_mux;
   logic             unused;

   assign wr      = bus.chipselect && !bus.write_n;
   assign wd      = bus.writedata[WIDTH-1:0];
   assign wr_data = wr && (bus.address == PIO_DATA);
   assign wr_set  = wr && (bus.address == PIO_SET);
   assign wr_clr  = wr && (bus.address == PIO_CLEAR);
   assign wr_mode = wr && (bus.address == PIO_MODE);
   assign wr_plen = wr && (bus.address == PIO_PLEN);

   // Writedata bits above WIDTH / CNT_W carry no meaning.
   assign unused = ^bus.writedata;

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q <= RESET_MODE;
         plen_q <= CNT_W'(1);
      end else begin
         if (wr_mode)
            mode_q <= wd;
         if (wr_plen)
            plen_q <= bus.writedata[CNT_W-1:0];
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      pio_pulse_out_chan #(
         .CNT_W   (CNT_W),
         .RST_OUT (RESET_VALUE[i] & ~RESET_MODE[i])
      ) u_chan (
         .clk      (clk),
         .reset    (reset),
         .mode     (mode_q[i]),
         .set      (wr_set & wd[i]),
         .clr      (wr_clr & wd[i]),
         .load     (wr_data),
         .load_val (wd[i]),
         .len      (plen_q),
         // Only channels whose mode actually flips are forced low.
         .mode_chg (wr_mode & (wd[i] ^ mode_q[i])),
         .out      (out_port[i]),
         .busy     (busy[i])
      );
   end

   always_comb begin
      rd_mux = '0;
      case (bus.address)
         PIO_DATA: rd_mux[WIDTH-1:0] = out_port;
         PIO_MODE: rd_mux[WIDTH-1:0] = mode_q;
         PIO_PLEN: rd_mux[CNT_W-1:0] = plen_q;
         PIO_BUSY: rd_mux[WIDTH-1:0] = busy;
         default:  rd_mux = '0;
      endcase
   end

   assign bus.readdata = rd_mux;

endmodule

// File: tb/tb_pio_pulse_out.sv
// tb_pio_pulse_out
//   Bench for pio_pulse_out (WIDTH=8, CNT_W=16, RESET_VALUE=A5, RESET_MODE=0).
//   A time-stamp model (per-channel level value or absolute pulse end cycle)
//   predicts out_port and readdata every cycle; directed scenarios add
//   literal expectations, then a randomized phase exercises the register map.
module tb_pio_pulse_out;
   import pio_pulse_out_pkg::*;

   localparam int               W   = 8;
   localparam int               CW  = 16;
   localparam logic [W-1:0]     RV  = 8'hA5;
   localparam logic [W-1:0]     RM  = 8'h00;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] out_port;

   pio_pulse_out_if bus();

   pio_pulse_out #(
      .WIDTH       (W),
      .CNT_W       (CW),
      .RESET_VALUE (RV),
      .RESET_MODE  (RM)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .out_port (out_port)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int           cyc = 0;
   bit           mvalid = 1'b0;
   logic [W-1:0] m_lvl, m_mode;
   logic [CW-1:0] m_plen;
   int           m_pend [W];   // pulse channel is high while cyc < m_pend

   function automatic int eff_len();
      return (m_plen == '0) ? 1 : int'(m_plen);
   endfunction

   initial begin
      logic [W-1:0] wd;
      forever begin
         @(posedge clk);
         cyc++;
         if (reset === 1'b1) begin
            m_lvl  = RV & ~RM;
            m_mode = RM;
            m_plen = 16'd1;
            for (int i = 0; i < W; i++) m_pend[i] = 0;
            mvalid = 1'b1;
         end else if (mvalid && bus.chipselect === 1'b1 && bus.write_n === 1'b0) begin
            wd = bus.writedata[W-1:0];
            case (bus.address)
               PIO_DATA:
                  for (int i = 0; i < W; i++)
                     if (m_mode[i]) begin
                        if (wd[i]) m_pend[i] = cyc + eff_len();
                     end else m_lvl[i] = wd[i];
               PIO_SET:
                  for (int i = 0; i < W; i++)
                     if (wd[i]) begin
                        if (m_mode[i]) m_pend[i] = cyc + eff_len();
                        else m_lvl[i] = 1'b1;
                     end
               PIO_CLEAR:
                  for (int i = 0; i < W; i++)
                     if (wd[i]) begin
                        m_pend[i] = 0;
                        m_lvl[i]  = 1'b0;
                     end
               PIO_MODE: begin
                  for (int i = 0; i < W; i++)
                     if (wd[i] != m_mode[i]) begin
                        m_pend[i] = 0;
                        m_lvl[i]  = 1'b0;
                     end
                  m_mode = wd;
               end
               PIO_PLEN: m_plen = bus.writedata[CW-1:0];
               default: ;
            endcase
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      logic [W-1:0]  e_out, e_busy;
      logic [31:0]   e_rd;
      forever begin
         @(posedge clk);
         #1;
         if (mvalid) begin
            for (int i = 0; i < W; i++) begin
               e_busy[i] = m_mode[i] && (cyc < m_pend[i]);
               e_out[i]  = m_mode[i] ? (cyc < m_pend[i]) : m_lvl[i];
            end
            case (bus.address)
               PIO_DATA: e_rd = 32'(e_out);
               PIO_MODE: e_rd = 32'(m_mode);
               PIO_PLEN: e_rd = 32'(m_plen);
               PIO_BUSY: e_rd = 32'(e_busy);
               default:  e_rd = 32'h0;
            endcase
            check("model_out_port", 32'(out_port), 32'(e_out));
            check("model_readdata", bus.readdata, e_rd);
         end
      end
   end

   // ---------------- bus helpers (called at a falling edge) ----------------
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.writedata  = d;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      bus.address = a;
      #1;
      d = bus.readdata;
      @(negedge clk);
   endtask

   // Counts consecutive high cycles of out_port[idx] starting now.
   task automatic count_high(input int idx, input bit chk_busy, output int n);
      n = 0;
      for (int k = 0; k < 64; k++) begin
         #1;
         if (!out_port[idx]) break;
         n++;
         if (chk_busy) check("busy_during_pulse", 32'(bus.readdata[idx]), 32'd1);
         @(negedge clk);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] d;
      int          n;
      reset          = 1'b1;
      bus.address    = '0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Reset state
      check("reset_out_port", 32'(out_port), 32'h0000_00A5);
      rd(PIO_MODE, d); check("reset_mode", d, 32'h0);
      rd(PIO_PLEN, d); check("reset_plen", d, 32'h1);
      rd(PIO_BUSY, d); check("reset_busy", d, 32'h0);

      // Level channels: DATA, SET, CLEAR
      wr(PIO_MODE, 32'h0);
      wr(PIO_DATA, 32'hFFFF_FF3C); check("level_data", 32'(out_port), 32'h3C);
      wr(PIO_SET, 32'h01);         check("level_set", 32'(out_port), 32'h3D);
      wr(PIO_CLEAR, 32'h0C);       check("level_clear", 32'(out_port), 32'h31);

      // 5-cycle pulse on channel 0 with BUSY visible
      wr(PIO_MODE, 32'h01);
      wr(PIO_PLEN, 32'd5);
      wr(PIO_DATA, 32'h01);
      bus.address = PIO_BUSY;
      count_high(0, 1'b1, n);
      check("pulse5_len", 32'(n), 32'd5);
      check("pulse5_busy_after", bus.readdata, 32'h0);

      // Retrigger on the 4th high cycle of a 4-cycle pulse
      wr(PIO_PLEN, 32'd4);
      wr(PIO_DATA, 32'h01);
      @(negedge clk);
      @(negedge clk);
      wr(PIO_SET, 32'h01);
      count_high(0, 1'b0, n);
      check("retrigger_len", 32'(n + 3), 32'd7);

      // PLEN=0 behaves as 1
      wr(PIO_PLEN, 32'd0);
      wr(PIO_SET, 32'h01);
      count_high(0, 1'b0, n);
      check("plen0_len", 32'(n), 32'd1);

      // CLEAR aborts a running pulse
      wr(PIO_PLEN, 32'd10);
      wr(PIO_DATA, 32'h01);
      @(negedge clk);
      wr(PIO_CLEAR, 32'h01);
      bus.address = PIO_BUSY;
      #1;
      check("abort_out", 32'(out_port[0]), 32'd0);
      check("abort_busy", bus.readdata, 32'h0);
      @(negedge clk);

      // MODE change mid-pulse drops only the changed channel
      wr(PIO_DATA, 32'hF1);
      @(negedge clk);
      wr(PIO_MODE, 32'h00);
      check("modechg_out", 32'(out_port), 32'hF0);
      @(negedge clk);
      @(negedge clk);
      check("modechg_hold", 32'(out_port), 32'hF0);

      // Reset during a 10-cycle pulse
      wr(PIO_MODE, 32'h01);
      wr(PIO_PLEN, 32'd10);
      wr(PIO_DATA, 32'h01);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_out", 32'(out_port), 32'hA5);
      for (int k = 0; k < 12; k++) @(negedge clk);
      check("midreset_no_residual", 32'(out_port), 32'hA5);

      // Unmapped address
      rd(3'd7, d); check("unmapped_read", d, 32'h0);
      wr(3'd7, 32'hFFFF_FFFF);
      check("unmapped_write", 32'(out_port), 32'hA5);

      // Randomized register traffic
      for (int k = 0; k < 600; k++) begin
         int unsigned r;
         logic [2:0]  a;
         logic [31:0] wdat;
         r = $urandom_range(0, 99);
         a = 3'($urandom_range(0, 7));
         wdat = $urandom;
         if (a == 3'(PIO_PLEN))
            wdat = (wdat & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
         if (r < 2) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end else if (r < 60) begin
            bus.address    = a;
            bus.writedata  = wdat;
            bus.chipselect = ($urandom_range(0, 9) != 0);
            bus.write_n    = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            bus.chipselect = 1'b0;
            bus.write_n    = 1'b1;
         end else begin
            bus.address = a;
            @(negedge clk);
         end
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
